// File: rtl/irq_collector.sv
// irq_collector: latches active-low interrupt requests as sticky flags.
// Flags are gated by a CPU-writable mask to drive the active-low cpu_int.
// Status, mask and missed-interrupt count are readable over the CPU bus.
module irq_collector #(
   parameter int          NSRC = 4,
   parameter logic [15:0] BASE = 16'hd019
) (
   input  logic            cpu_clk,
   input  logic            rst,
   input  logic [15:0]     addr,
   input  logic [7:0]      data_in,
   input  logic            cpu_rwb,
   input  logic [NSRC-1:0] src_int_n,
   output logic [7:0]      data_out,
   output logic            send_out,
   output logic            cpu_int
);

   localparam logic [15:0] STAT_ADDR = BASE;
   localparam logic [15:0] MASK_ADDR = BASE + 16'd1;
   localparam logic [15:0] MISS_ADDR = BASE + 16'd2;

   logic [NSRC-1:0] prev;
   logic [NSRC-1:0] flags;
   logic [NSRC-1:0] mask;
   logic [7:0]      miss;

   logic [NSRC-1:0] fire;
   logic [NSRC-1:0] clr;
   logic            dup;
   logic            wr_stat;
   logic            wr_mask;
   logic            wr_miss;
   logic            rd_hit;
   logic [7:0]      rd_val;
   logic [7:0]      stat_val;

   // Falling-edge detect, write decode and duplicate-fire detection
   always_comb begin
      fire    = prev & ~src_int_n;
      wr_stat = !cpu_rwb && (addr == STAT_ADDR);
      wr_mask = !cpu_rwb && (addr == MASK_ADDR);
      wr_miss = !cpu_rwb && (addr == MISS_ADDR);
      clr     = wr_stat ? data_in[NSRC-1:0] : '0;
      dup     = |(fire & flags);
   end

   // Read data mux; status packs any-pending in bit 7 above the raw flags
   always_comb begin
      stat_val            = '0;
      stat_val[NSRC-1:0]  = flags;
      stat_val[7]         = |(flags & mask);
      rd_hit              = 1'b0;
      rd_val              = '0;
      if (cpu_rwb) begin
         if (addr == STAT_ADDR) begin
            rd_hit = 1'b1;
            rd_val = stat_val;
         end else if (addr == MASK_ADDR) begin
            rd_hit = 1'b1;
            rd_val = {{(8-NSRC){1'b0}}, mask};
         end else if (addr == MISS_ADDR) begin
            rd_hit = 1'b1;
            rd_val = miss;
         end
      end
   end

   // Sticky flags (set wins over clear), mask and saturating miss counter
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         prev  <= '1;
         flags <= '0;
         mask  <= '0;
         miss  <= '0;
      end else begin
         prev  <= src_int_n;
         flags <= (flags & ~clr) | fire;
         if (wr_mask)
            mask <= data_in[NSRC-1:0];
         if (wr_miss)
            miss <= dup ? 8'd1 : 8'd0;
         else if (dup && (miss != 8'hff))
            miss <= miss + 8'd1;
      end
   end

   // Registered interrupt output and bus read port
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         cpu_int  <= 1'b1;
         send_out <= 1'b0;
         data_out <= '0;
      end else begin
         cpu_int  <= !(|(flags & mask));
         send_out <= rd_hit;
         if (rd_hit)
            data_out <= rd_val;
      end
   end

endmodule

// File: doc/irq_collector.md
# irq_collector

Collects active-low interrupt requests from the video interrupt generator and other peripherals, latches each as a sticky flag, gates them with a CPU-writable mask and drives the single active-low `cpu_int` line into the 6502-style CPU. Sits directly downstream of the raster-interrupt block: that block's one-cycle `cpu_int` pulse enters here as `src_int_n[0]`. The block exposes status, mask and missed-interrupt registers on the CPU bus using the same registered `data_out`/`send_out` read scheme as the other bus peripherals.

## Interface
- `NSRC`, 4: number of interrupt sources, legal range 1..7.
- `BASE`, 16'hd019: status register address; mask is at `BASE+1`, miss counter at `BASE+2`.

Ports:
- `cpu_clk`  in  1  system/CPU clock; all state changes on its rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `addr`  in  16  CPU address bus.
- `data_in`  in  8  CPU write data.
- `cpu_rwb`  in  1  1 = read, 0 = write.
- `src_int_n`  in  NSRC  active-low requests; bit 0 is the raster interrupt.
- `data_out`  out  8  registered read data.
- `send_out`  out  1  1 = `data_out` valid for this block's address.
- `cpu_int`  out  1  active-low interrupt to the CPU.

## Operation
- State: `prev[NSRC]` (last sampled `src_int_n`), `flags[NSRC]`, `mask[NSRC]`, `miss[8]`.
- Edge detect: a source fires when `prev[i]==1 && src_int_n[i]==0`. `prev` updates every cycle. Level-low sources fire once per falling edge, not per cycle.
- Flag set: a firing source sets `flags[i]`. Set takes priority over a same-cycle write-1-to-clear of that bit.
- Miss counter: it increments by exactly 1 in any cycle where at least one firing source already has its flag set. It saturates at 255.
- Status read at `BASE`: returns `{any, 0 padding, flags}`. `flags` occupies bits [NSRC-1:0], bit 7 is `any = |(flags & mask)`, and the bits between are 0.
- Status write at `BASE`: every `flags[i]` whose `data_in[i]==1` is cleared. Bit 7 and the other bits are ignored.
- Mask read/write at `BASE+1`: `mask = data_in[NSRC-1:0]`. A read returns the mask zero-extended.
- Miss read at `BASE+2`: returns `miss`, and reading it is non-destructive. Any write there clears it to 0. If an increment condition occurs in the same cycle as that write, the result is 1.
- Interrupt output: `cpu_int <= !(|(flags & mask))` every cycle. Masking or unmasking an already-set flag takes effect on that path.
- Bus read, `cpu_rwb==1` at one of the three addresses: `data_out` is loaded and `send_out<=1`. Any other read address, or any write cycle, gives `send_out<=0`, and `data_out` holds its last value.
- Unused `data_in` bits are ignored. Addresses outside `BASE..BASE+2` have no effect.

## Timing
- Reset values: `data_out=0`, `send_out=0`, `cpu_int=1`, `flags=0`, `mask=0`, `miss=0`, `prev=all 1`.
- Consequence of the `prev` reset value: a source held low through reset fires once on the first cycle after reset.
- Source to flag: `src_int_n[i]` is sampled low at edge N, and `flags[i]` is 1 after edge N.
- Flag to CPU: `cpu_int` goes low after edge N+1 (2-edge latency from the sample), provided `mask[i]` is 1.
- Clear to release: a status write sampled at edge M clears the flag at edge M. `cpu_int` returns high after edge M+1 if no other masked flag is set.
- Mask write at edge M: `cpu_int` reflects the new mask after edge M+1.
- Read: an address presented at edge M gives `data_out`/`send_out` valid after edge M, for one cycle per addressed cycle. Values are those of the state before edge M.
- Reset mid-operation: all state returns to reset values at the next edge, with no partial updates. `cpu_int` is 1 after that edge.
- A one-cycle low pulse is caught. Back-to-back pulses separated by a single high cycle fire twice.

## Test plan
- Reset, then `mask=8'h01`, then pulse `src_int_n[0]` low for 1 cycle. Required: `flags[0]=1` after the sample edge and `cpu_int=0` one edge later. A read of `BASE` returns `8'h81`. Writing `8'h01` to `BASE` returns `cpu_int` to 1 within 2 edges.
- `mask=0`, pulse source 2. Required: status read = `8'h04` and `cpu_int` stays 1. Then writing `mask=8'h04` gives `cpu_int=0` after 1 edge.
- Hold source 1 low for 10 cycles, then clear its flag. Required: only 1 set event and `miss` stays 0. A second falling edge with the flag still set gives `miss=1`.
- 300 falling edges on source 0 with its flag never cleared. Required: `miss=8'hFF`. A write to `BASE+2` gives 0. A write coinciding with an edge gives 1.
- Source 3 falls in the same cycle as a write of `8'h08` to `BASE`. Required: `flags[3]` remains 1.
- Assert `rst` for 1 cycle while `cpu_int=0` and `send_out=1`. Required: all outputs at reset values after that edge. A source held low through reset fires once afterwards.
